// File: rtl/rr_merge_scheduler.sv
// Round-robin N-input merge scheduler with packet locking and a single registered output stage.
// Optional per-input completed-packet counters are built when RR_MERGE_STATS_EN is defined.
module rr_merge_scheduler #(
  parameter int N     = 4,
  parameter int WIDTH = 33,
  parameter int CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [N-1:0]          in_valid,
  output logic [N-1:0]          in_ready,
  input  logic [N*WIDTH-1:0]    in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic [$clog2(N)-1:0]  out_src,
  output logic [N*CNT_W-1:0]    pkt_count
);

  localparam int IDX_W = $clog2(N);

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_LOCKED = 1'b1} state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic               out_valid_q, out_valid_d;
  logic [WIDTH-1:0]   out_data_q, out_data_d;
  logic [IDX_W-1:0]   out_src_q, out_src_d;

  logic [N-1:0]       lo_mask_s;
  logic [N-1:0]       hi_req_s;
  logic               found_s;
  logic [IDX_W-1:0]   win_s;
  logic [IDX_W-1:0]   sel_s;
  logic [WIDTH-1:0]   acc_data_s;
  logic               can_load_s;
  logic               accept_s;
  logic               tail_s;
  logic [N-1:0]       in_ready_s;

  // Lowest set bit wins; scanned top-down so the final write is the lowest index.
  function automatic logic [IDX_W-1:0] first_set(input logic [N-1:0] v);
    logic [IDX_W-1:0] r;
    r = '0;
    for (int i = N - 1; i >= 0; i--) begin
      r = v[i] ? IDX_W'(i) : r;
    end
    return r;
  endfunction

  // Wrap at N-1 so non-power-of-two N never reaches unused codes.
  function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] v);
    return (v == IDX_W'(N - 1)) ? '0 : v + 1'b1;
  endfunction

  // Rotating-priority winner: requests at or above ptr first, then the wrapped ones.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      lo_mask_s[i] = (IDX_W'(i) < ptr_q);
    end
    hi_req_s = in_valid & ~lo_mask_s;
    found_s  = |in_valid;
    win_s    = (|hi_req_s) ? first_set(hi_req_s) : first_set(in_valid);
  end

  // Handshake, output-register load and lock/pointer update.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    ptr_d       = ptr_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_src_d   = out_src_q;
    in_ready_s  = '0;
    acc_data_s  = '0;

    can_load_s = !out_valid_q || out_ready;
    sel_s      = (state_q == ST_LOCKED) ? owner_q : win_s;
    for (int i = 0; i < N; i++) begin
      acc_data_s = (IDX_W'(i) == sel_s) ? in_data[i*WIDTH +: WIDTH] : acc_data_s;
    end
    tail_s = acc_data_s[WIDTH-1];

    case (state_q)
      ST_IDLE:   in_ready_s[win_s]   = found_s && can_load_s && !reset;
      ST_LOCKED: in_ready_s[owner_q] = can_load_s && !reset;
      default:   in_ready_s          = '0;
    endcase

    accept_s = |(in_valid & in_ready_s);

    if (accept_s) begin
      out_valid_d = 1'b1;
      out_data_d  = acc_data_s;
      out_src_d   = sel_s;
      if (tail_s) begin
        state_d = ST_IDLE;
        ptr_d   = wrap_inc(sel_s);
      end else begin
        state_d = ST_LOCKED;
        owner_d = sel_s;
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // Scheduler state and output register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      owner_q     <= '0;
      ptr_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      ptr_q       <= ptr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_src_q   <= out_src_d;
    end
  end

  assign in_ready  = in_ready_s;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_src   = out_src_q;

`ifdef RR_MERGE_STATS_EN
  logic [CNT_W-1:0] cnt_q [N];
  logic [CNT_W-1:0] cnt_d [N];

  // Saturating count of accepted tail flits per input.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      cnt_d[i] = cnt_q[i];
      if (accept_s && tail_s && (sel_s == IDX_W'(i)) && (cnt_q[i] != {CNT_W{1'b1}})) begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end else begin
        cnt_d[i] = cnt_q[i];
      end
    end
  end

  // Counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < N; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  // Flatten counters onto the output bus.
  always_comb begin
    pkt_count = '0;
    for (int i = 0; i < N; i++) begin
      pkt_count[i*CNT_W +: CNT_W] = cnt_q[i];
    end
  end
`else
  assign pkt_count = '0;
`endif

endmodule

// File: tb/tb_rr_merge_scheduler.sv
// Scoreboard bench for rr_merge_scheduler: directed flits per input, expected outputs queued by hand.
module tb_rr_merge_scheduler;

  localparam int N     = 4;
  localparam int WIDTH = 33;
  localparam int CNT_W = 4;

  logic                 clk;
  logic                 reset;
  logic [N-1:0]         in_valid;
  logic [N-1:0]         in_ready;
  logic [N*WIDTH-1:0]   in_data;
  logic                 out_valid;
  logic                 out_ready;
  logic [WIDTH-1:0]     out_data;
  logic [1:0]           out_src;
  logic [N*CNT_W-1:0]   pkt_count;

  rr_merge_scheduler #(.N(N), .WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_src(out_src), .pkt_count(pkt_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [WIDTH-1:0] mem [N][32];
  int               head [N];
  int               tail [N];
  logic [34:0]      exp_q [$];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  function automatic logic [WIDTH-1:0] fl(input logic t, input logic [31:0] p);
    return {t, p};
  endfunction

  task automatic present();
    for (int i = 0; i < N; i++) begin
      if (head[i] < tail[i]) begin
        in_valid[i] = 1'b1;
        in_data[i*WIDTH +: WIDTH] = mem[i][head[i]];
      end else begin
        in_valid[i] = 1'b0;
        in_data[i*WIDTH +: WIDTH] = '0;
      end
    end
  endtask

  task automatic add_flit(input int i, input logic [WIDTH-1:0] d);
    mem[i][tail[i]] = d;
    tail[i]++;
  endtask

  task automatic expect_out(input int s, input logic [WIDTH-1:0] d);
    exp_q.push_back({2'(s), d});
  endtask

  // Handshakes are sampled on the falling edge; inputs change 1 time unit after the rising edge.
  task automatic cycle();
    logic [N-1:0] fire;
    @(negedge clk);
    fire = in_valid & in_ready;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) if (fire[i]) head[i]++;
    present();
  endtask

  function automatic bit pending();
    for (int i = 0; i < N; i++) if (head[i] < tail[i]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic drain(input string name, input int budget);
    int n;
    n = 0;
    while ((pending() || exp_q.size() != 0 || out_valid) && n < budget) begin
      cycle();
      n++;
    end
    if (n >= budget) begin
      total++;
      bad++;
      $display("FAIL %s timeout left=%0d", name, exp_q.size());
    end
  endtask

  // Monitor: every transfer on the output channel must match the next expected flit.
  initial begin
    logic [34:0] e;
    forever begin
      @(negedge clk);
      if (!reset && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_flit", {29'd0, out_src, out_data}, 64'hDEAD);
        end else begin
          e = exp_q.pop_front();
          check("out_flit", {29'd0, out_src, out_data}, {29'd0, e});
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N*CNT_W-1:0] exp_cnt;
    for (int i = 0; i < N; i++) begin head[i] = 0; tail[i] = 0; end
    reset     = 1'b1;
    out_ready = 1'b1;
    in_valid  = 4'b1111;
    in_data   = '0;

    // Reset state, with requests already pending.
    #12;
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_out_data", {31'd0, out_data}, 64'd0);
    check("rst_out_src", {62'd0, out_src}, 64'd0);
    check("rst_in_ready", {60'd0, in_ready}, 64'd0);
    check("rst_pkt_count", {48'd0, pkt_count}, 64'd0);
    in_valid = 4'b0000;
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (3) cycle();
    check("idle_out_valid", {63'd0, out_valid}, 64'd0);
    check("idle_out_data", {31'd0, out_data}, 64'd0);

    // Single-flit round robin, all inputs requesting.
    for (int k = 0; k < 3; k++)
      for (int i = 0; i < N; i++) begin
        add_flit(i, fl(1'b1, 32'(i * 16 + k)));
        expect_out(i, fl(1'b1, 32'(i * 16 + k)));
      end
    present();
    repeat (13) cycle();
    check("rr_no_bubble", 64'(exp_q.size()), 64'd0);
    drain("rr_drain", 50);

    // Packet lock: input 2 owns the channel while 3 and 0 wait.
    add_flit(1, fl(1'b1, 32'h20));
    expect_out(1, fl(1'b1, 32'h20));
    present();
    drain("lock_pre", 50);
    add_flit(2, fl(1'b0, 32'h10));
    add_flit(2, fl(1'b0, 32'h11));
    add_flit(2, fl(1'b1, 32'h12));
    add_flit(3, fl(1'b1, 32'h30));
    add_flit(0, fl(1'b1, 32'h40));
    expect_out(2, fl(1'b0, 32'h10));
    expect_out(2, fl(1'b0, 32'h11));
    expect_out(2, fl(1'b1, 32'h12));
    expect_out(3, fl(1'b1, 32'h30));
    expect_out(0, fl(1'b1, 32'h40));
    present();
    drain("lock", 50);

    // Backpressure: output held for 5 cycles, nothing accepted.
    out_ready = 1'b0;
    add_flit(1, 33'h1_0000_0005);
    add_flit(2, 33'h1_0000_0006);
    expect_out(1, 33'h1_0000_0005);
    expect_out(2, 33'h1_0000_0006);
    present();
    cycle();
    for (int c = 0; c < 5; c++) begin
      cycle();
      check("bp_out_valid", {63'd0, out_valid}, 64'd1);
      check("bp_out_data", {31'd0, out_data}, 64'h1_0000_0005);
      check("bp_in_ready", {60'd0, in_ready}, 64'd0);
    end
    out_ready = 1'b1;
    drain("bp", 50);

    // Async reset in the middle of a locked packet from input 1.
    add_flit(1, fl(1'b0, 32'h51));
    add_flit(1, fl(1'b0, 32'h52));
    add_flit(1, fl(1'b1, 32'h53));
    present();
    cycle();
    reset = 1'b1;
    #2;
    check("arst_out_valid", {63'd0, out_valid}, 64'd0);
    check("arst_in_ready", {60'd0, in_ready}, 64'd0);
    head[1] = tail[1];
    present();
    cycle();
    reset = 1'b0;
    check("arst_pkt_count", {48'd0, pkt_count}, 64'd0);
    add_flit(3, fl(1'b1, 32'h63));
    add_flit(2, fl(1'b1, 32'h62));
    expect_out(2, fl(1'b1, 32'h62));
    expect_out(3, fl(1'b1, 32'h63));
    present();
    drain("post_rst", 50);

    // Counters: 20 single-flit packets from input 0 after a clean reset.
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    for (int k = 0; k < 20; k++) begin
      add_flit(0, fl(1'b1, 32'(k)));
      expect_out(0, fl(1'b1, 32'(k)));
    end
    present();
    drain("stats", 200);
`ifdef RR_MERGE_STATS_EN
    exp_cnt = 16'h000F;
`else
    exp_cnt = 16'h0000;
`endif
    check("pkt_count", {48'd0, pkt_count}, {48'd0, exp_cnt});
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rr_merge_scheduler.md
# rr_merge_scheduler

Clocked N-input round-robin scheduler that shares one 33-bit packet output channel between several requesters. It forms the arbitration and merge stage in front of a router output port. Multi-flit packets are locked to their winner until the tail flit passes. Output is a single registered stage with full throughput.

## Interface
- N, 4, number of requesters (2..8)
- WIDTH, 33, flit width; bit WIDTH-1 is the tail (last) flag, bits WIDTH-2:0 payload
- CNT_W, 16, width of per-input packet counters (stats build only)

- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- in_valid  input  N  requester i has a flit
- in_ready  output  N  flit i accepted this cycle when in_valid[i] && in_ready[i]
- in_data  input  N*WIDTH  flit i at in_data[i*WIDTH +: WIDTH]
- out_valid  output  1  registered flit present
- out_ready  input  1  downstream accepts
- out_data  output  WIDTH  registered flit
- out_src  output  $clog2(N)  index of requester that sent out_data
- pkt_count  output  N*CNT_W  per-input completed-packet counters (see Configuration)

## Operation
- One clock, one reset. Reset is asynchronous, active-high.
- State: IDLE or LOCKED, plus owner, priority pointer ptr, and output register (out_valid, out_data, out_src).
- can_load = !out_valid || out_ready.
- IDLE:
  - winner = first i with in_valid[i], scanning ptr, ptr+1, … mod N.
  - If a winner exists and can_load: in_ready[winner]=1, flit loads into the output register.
  - If the flit's tail=1: stay IDLE, ptr <= winner+1 mod N.
  - If tail=0: go LOCKED, owner <= winner.
- LOCKED:
  - Only in_ready[owner] may be 1, and only when can_load. All other inputs wait even if valid.
  - On an accepted owner flit with tail=1: go IDLE, ptr <= owner+1 mod N.
- in_ready is combinational from in_valid, state, ptr, out_valid and out_ready. It has no dependency on in_data except through the registered state.
- When out_valid && !out_ready, out_data and out_src hold stable and all in_ready are 0.
- When out_valid && out_ready with no new accept, out_valid <= 0.
- A requester must hold in_valid and in_data until accepted. Dropping in_valid mid-packet in LOCKED stalls the scheduler; it is not an error.

## Timing
- Reset values:
  - out_valid=0, out_data=0, out_src=0
  - state=IDLE, ptr=0, owner=0
  - pkt_count=0
  - in_ready=0 while reset is asserted.
- Latency: a flit accepted at edge k appears with out_valid=1 after edge k, i.e. 1 cycle.
- Throughput: 1 flit/cycle when out_ready=1 continuously. Back-to-back single-flit packets from different inputs rotate with no bubble.
- Simultaneous requests: the lowest index at or after ptr wins. After every completed packet, the finishing input gets lowest priority.
- Reset asserted mid-packet: output register is cleared and the lock is released immediately (async). The partial packet is discarded downstream's responsibility.
- N not a power of two: ptr wraps from N-1 to 0, never reaching unused codes.

## Configuration
- RR_MERGE_STATS_EN defined:
  - pkt_count[i] increments by 1 on each accepted tail flit from input i.
  - Saturates at 2^CNT_W-1.
  - Cleared by reset.
- RR_MERGE_STATS_EN undefined: pkt_count is tied to 0 and no counter flops are built. Scheduling behaviour is identical.

## Test plan
- Reset then idle: after reset, out_valid=0, out_data=0, out_src=0, in_ready=0000. Deassert reset with no valids; outputs remain 0.
- Single-flit round robin: N=4, all in_valid=1111, every flit tail=1, out_ready=1. out_src sequence is 0,1,2,3,0,… with one flit per cycle; first out_valid appears one cycle after the first accept.
- Packet lock: input 2 sends 3 flits (tails 0,0,1), payloads 0x10,0x11,0x12, while input 0 is valid throughout. Output is 0x10,0x11,0x12 with src=2, then input 0's flit; ptr=3 after the packet.
- Backpressure: hold out_ready=0 for 5 cycles with out_valid=1 and data 0x1_00000005. out_data holds, in_ready=0000, no flit is lost or duplicated; release, and the next flit follows in the next cycle.
- Async reset mid-packet: assert reset between flits 1 and 2 of a locked packet from input 1. out_valid drops to 0 without a clock edge; after release input 3 can win immediately (ptr=0 scan: 0,1,2,3).
- Stats (RR_MERGE_STATS_EN, CNT_W=4): 20 single-flit packets from input 0. pkt_count[0] saturates at 15; others stay 0. Without the macro, pkt_count=0 throughout.
